// File: rtl/pwm_timer.sv
// ---------------------------------------------------------------------------
// pwm_timer -- memory-mapped PWM timer for a picosoc iomem bus.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   resetn       synchronous active-low reset
//   iomem_valid  bus request
//   iomem_ready  one-cycle acknowledge of an accepted access
//   iomem_wstrb  byte write strobes (4'b0000 = read)
//   iomem_addr   byte address; decoded when [31:8] == BASE_ADDR[31:8]
//   iomem_wdata  write data
//   iomem_rdata  read data, loaded when iomem_ready rises
//   pwm_out      PWM waveform
//   irq          level interrupt (STATUS.WRAP && CTRL.IRQ_EN)
//
// Register map (offset): 0x00 CTRL {INVERT,ONESHOT,IRQ_EN,EN}, 0x04 PERIOD,
// 0x08 DUTY, 0x0C COUNT, 0x10 STATUS {WRAP}. Other offsets read 0.
//
// Build option: define PWM_TIMER_SHADOW_EN to buffer PERIOD/DUTY writes in
// shadow registers that are copied to the active registers on the next wrap
// (or immediately while EN=0). Default build: writes apply directly.
// ---------------------------------------------------------------------------
module pwm_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0300
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        pwm_out,
  output logic        irq
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_DUTY   = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [3:0]  ctrl_q,   ctrl_d;
  logic [31:0] period_q, period_d;
  logic [31:0] duty_q,   duty_d;
  logic [31:0] count_q,  count_d;
  logic        status_q, status_d;
  logic        ready_q,  ready_d;
  logic [31:0] rdata_q,  rdata_d;
`ifdef PWM_TIMER_SHADOW_EN
  logic [31:0] period_sh_q, period_sh_d;
  logic [31:0] duty_sh_q,   duty_sh_d;
`endif

  logic       accept_s;
  logic       wr_s;
  logic [7:0] off_s;
  logic       run_s;
  logic       wrap_s;
  logic       wr_count_s;

  assign off_s      = iomem_addr[7:0];
  // ready_q blocks re-acceptance of the request still held during the ack cycle.
  assign accept_s   = iomem_valid && !ready_q && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  assign wr_s       = accept_s && (iomem_wstrb != 4'b0000);
  assign wr_count_s = wr_s && (off_s == OFF_COUNT);
  assign run_s      = ctrl_q[0] && (period_q != 32'd0);
  // A COUNT write overrides the wrap entirely (no WRAP flag, no one-shot stop).
  assign wrap_s     = run_s && (count_q >= period_q) && !wr_count_s;

  // Next-state logic for bus interface, counter and configuration registers.
  always_comb begin
    ready_d  = accept_s;
    rdata_d  = rdata_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty_d   = duty_q;
    count_d  = count_q;
    status_d = status_q;
`ifdef PWM_TIMER_SHADOW_EN
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
`endif

    // Read data reflects register contents before this access's write.
    if (accept_s) begin
      case (off_s)
        OFF_CTRL:   rdata_d = {28'd0, ctrl_q};
`ifdef PWM_TIMER_SHADOW_EN
        OFF_PERIOD: rdata_d = period_sh_q;
        OFF_DUTY:   rdata_d = duty_sh_q;
`else
        OFF_PERIOD: rdata_d = period_q;
        OFF_DUTY:   rdata_d = duty_q;
`endif
        OFF_COUNT:  rdata_d = count_q;
        OFF_STATUS: rdata_d = {31'd0, status_q};
        default:    rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    // Software write to CTRL takes precedence over a one-shot stop.
    if (wr_s && (off_s == OFF_CTRL)) begin
      ctrl_d = iomem_wstrb[0] ? iomem_wdata[3:0] : ctrl_q;
    end else if (wrap_s && ctrl_q[2]) begin
      ctrl_d = {ctrl_q[3:1], 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_count_s) begin
      count_d = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
    end else if (wrap_s) begin
      count_d = 32'd0;
    end else if (run_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    // Set wins over a coincident write-1-to-clear.
    if (wrap_s) begin
      status_d = 1'b1;
    end else if (wr_s && (off_s == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[0]) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end

`ifdef PWM_TIMER_SHADOW_EN
    if (wr_s && (off_s == OFF_PERIOD)) begin
      period_sh_d = merge_bytes(period_sh_q, iomem_wdata, iomem_wstrb);
    end else begin
      period_sh_d = period_sh_q;
    end
    if (wr_s && (off_s == OFF_DUTY)) begin
      duty_sh_d = merge_bytes(duty_sh_q, iomem_wdata, iomem_wstrb);
    end else begin
      duty_sh_d = duty_sh_q;
    end
    // Shadow contents go live at a period boundary, or at once while stopped.
    if (wrap_s || !ctrl_q[0]) begin
      period_d = period_sh_d;
      duty_d   = duty_sh_d;
    end else begin
      period_d = period_q;
      duty_d   = duty_q;
    end
`else
    if (wr_s && (off_s == OFF_PERIOD)) begin
      period_d = merge_bytes(period_q, iomem_wdata, iomem_wstrb);
    end else begin
      period_d = period_q;
    end
    if (wr_s && (off_s == OFF_DUTY)) begin
      duty_d = merge_bytes(duty_q, iomem_wdata, iomem_wstrb);
    end else begin
      duty_d = duty_q;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q      <= 4'd0;
      period_q    <= 32'd0;
      duty_q      <= 32'd0;
      count_q     <= 32'd0;
      status_q    <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
`ifdef PWM_TIMER_SHADOW_EN
      period_sh_q <= 32'd0;
      duty_sh_q   <= 32'd0;
`endif
    end else begin
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      count_q     <= count_d;
      status_q    <= status_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
`ifdef PWM_TIMER_SHADOW_EN
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  // DUTY above PERIOD means the compare never fails within a period: full on.
  assign pwm_out = (ctrl_q[0] && ((duty_q > period_q) || (count_q < duty_q))) ^ ctrl_q[3];
  assign irq     = status_q && ctrl_q[1];

endmodule

// File: doc/pwm_timer.md
PWM_TIMER -- requirements
Module: pwm_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0300, iomem base; decodes when iomem_addr[31:8] == BASE_ADDR[31:8].
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port iomem_valid  input  1  bus request from picosoc.
REQ-005 SHALL have port iomem_ready  output  1  one-cycle acknowledge.
REQ-006 SHALL have port iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-007 SHALL have port iomem_addr  input  32  byte address.
REQ-008 SHALL have port iomem_wdata  input  32  write data.
REQ-009 SHALL have port iomem_rdata  output  32  read data.
REQ-010 SHALL have port pwm_out  output  1  PWM waveform (LED/pin drive).
REQ-011 SHALL have port irq  output  1  level interrupt toward a picosoc irq_5..7 input.

Function
REQ-012 Register map by iomem_addr[7:0]: 0x00 CTRL, 0x04 PERIOD, 0x08 DUTY, 0x0C COUNT, 0x10 STATUS; other offsets read 0 and ignore writes.
REQ-013 CTRL bits: [0] EN, [1] IRQ_EN, [2] ONESHOT, [3] INVERT; [31:4] read 0.
REQ-014 Access accepted when iomem_valid && !iomem_ready && address match; iomem_ready = 1 on the next cycle for exactly one cycle, then 0.
REQ-015 On an accepted access, iomem_rdata loads the addressed register in the same edge as iomem_ready rises; otherwise it holds.
REQ-016 Writes honour each wstrb bit per byte lane; registered value visible on the cycle after iomem_ready.
REQ-017 With EN=1 and PERIOD!=0, COUNT increments by 1 per clk; when COUNT >= PERIOD the next COUNT is 0 (wrap), so a full period spans PERIOD+1 cycles.
REQ-018 With EN=0 or PERIOD==0, COUNT holds its value and no wrap occurs.
REQ-019 On wrap, STATUS[0] (WRAP) sets on the same edge COUNT goes to 0; if ONESHOT=1, CTRL.EN clears on that edge.
REQ-020 STATUS[0] clears only by writing 1 to bit 0; a clear coinciding with a new wrap leaves it set (set wins).
REQ-021 A write to COUNT loads wdata (per byte lanes) and overrides that cycle's increment/wrap.
REQ-022 pwm_out = ((COUNT < DUTY_active) && EN) XOR INVERT, combinational from registers only; DUTY_active > PERIOD_active gives constant high (pre-invert).
REQ-023 irq = STATUS[0] && CTRL[1].
REQ-024 Counter arithmetic is 32-bit unsigned; COUNT = 32'hFFFF_FFFF with PERIOD = 32'hFFFF_FFFF wraps to 0, never overflows past.

Reset
REQ-025 When resetn=0 at a clk edge: CTRL, PERIOD, DUTY, COUNT, STATUS, shadow registers, iomem_ready and iomem_rdata all become 0; pwm_out=0, irq=0.
REQ-026 Reset mid-transaction drops the access with no iomem_ready; picosoc retries after reset.

Configuration
REQ-027 Macro PWM_TIMER_SHADOW_EN defined: PERIOD/DUTY writes land in shadow registers, copied to active on the next wrap, or immediately while EN=0; reads return shadow value.
REQ-028 Macro PWM_TIMER_SHADOW_EN undefined: PERIOD/DUTY writes take effect on the next cycle; COUNT > new PERIOD causes a wrap on the next enabled cycle.

Verification
REQ-029 Reset, read 0x00-0x10 -> all read 0, each iomem_ready high exactly one cycle, pwm_out=0, irq=0.
REQ-030 PERIOD=9, DUTY=3, CTRL=1 -> COUNT 0..9 repeats, pwm_out high 3 of every 10 cycles; CTRL=9 -> inverted (low 3 of 10).
REQ-031 PERIOD=4, CTRL=0x7 -> one wrap after 5 cycles, STATUS=1, irq=1, EN reads 0; write STATUS=1 -> irq=0.
REQ-032 Write STATUS=1 on the exact cycle of a wrap -> STATUS[0] remains 1.
REQ-033 Running PERIOD=99, COUNT at 50, write PERIOD=20 -> SHADOW_EN: wrap at 99, then 21-cycle periods; no SHADOW_EN: wrap on next cycle.
REQ-034 Write wstrb=4'b0001 wdata=32'hAABBCCDD to DUTY=0 -> DUTY reads 32'h0000_00DD; access to offset 0x14 -> reads 0, ready still pulses.
